dp_lat_mem_ctrl: RTL and testbench

Dual-port memory controller (the DUT behind the two `ram_if` port instances). Each port issues single-beat read or write requests with no backpressure. Writes commit to a shared storage array after a per-port write latency. Read data returns on `dout` after a per-port read latency. Delays come from internal per-port request and response pipelines; the array is split into address-interleaved banks.

---
 rtl/dp_lat_mem_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_dp_lat_mem_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_lat_mem_ctrl.sv
// Dual-port, latency-configurable memory controller.
// Each port feeds a write pipeline (commit after W_LATp edges) and a read
// pipeline (data on dout after R_LATp edges). Storage is split into
// address-interleaved banks. Each bank has two write ports and two registered
// read ports. When both ports commit to the same word on one edge, port 0 wins.

// Write request delay line: {valid, bank, index, data}; the last stage commits.
module dp_lat_wr_pipe #(
    parameter int LAT = 3,
    parameter int B_W = 1,
    parameter int I_W = 5,
    parameter int D_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld_i,
    input  logic [B_W-1:0] in_bank_i,
    input  logic [I_W-1:0] in_idx_i,
    input  logic [D_W-1:0] in_data_i,
    output logic           out_vld_o,
    output logic [B_W-1:0] out_bank_o,
    output logic [I_W-1:0] out_idx_o,
    output logic [D_W-1:0] out_data_o
);
    logic           vld_q  [LAT];
    logic [B_W-1:0] bank_q [LAT];
    logic [I_W-1:0] idx_q  [LAT];
    logic [D_W-1:0] data_q [LAT];

    // Shift every request one stage per edge; reset drops all in-flight writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                vld_q[k]  <= 1'b0;
                bank_q[k] <= '0;
                idx_q[k]  <= '0;
                data_q[k] <= '0;
            end
        end else begin
            vld_q[0]  <= in_vld_i;
            bank_q[0] <= in_bank_i;
            idx_q[0]  <= in_idx_i;
            data_q[0] <= in_data_i;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k]  <= vld_q[k-1];
                bank_q[k] <= bank_q[k-1];
                idx_q[k]  <= idx_q[k-1];
                data_q[k] <= data_q[k-1];
            end
        end
    end

    assign out_vld_o  = vld_q[LAT-1];
    assign out_bank_o = bank_q[LAT-1];
    assign out_idx_o  = idx_q[LAT-1];
    assign out_data_o = data_q[LAT-1];
endmodule

// Read response delay line. req_i marks a read sampled at edge E. data_i is
// the bank read data captured at E, so it is valid while stage 0 is valid.
// dout/dvld update at E+LAT, and dout holds between completed reads.
module dp_lat_rd_pipe #(
    parameter int LAT = 2,
    parameter int D_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_i,
    input  logic [D_W-1:0] data_i,
    output logic [D_W-1:0] dout_o,
    output logic           dvld_o
);
    logic           vld_q [LAT];
    logic           dvld_q;
    logic [D_W-1:0] dout_q;

    // Valid bits walk LAT stages; the tail becomes the one-cycle dvld pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                vld_q[k] <= 1'b0;
            end
            dvld_q <= 1'b0;
        end else begin
            vld_q[0] <= req_i;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            dvld_q <= vld_q[LAT-1];
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            // Bank data goes straight to the output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (vld_q[0]) begin
                    dout_q <= data_i;
                end
            end
        end else begin : g_latn
            logic [D_W-1:0] data_q [LAT-1];

            // Data stages trail stage 0 by one; the output loads only on completion.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < LAT - 1; k++) begin
                        data_q[k] <= '0;
                    end
                    dout_q <= '0;
                end else begin
                    data_q[0] <= data_i;
                    for (int k = 1; k < LAT - 1; k++) begin
                        data_q[k] <= data_q[k-1];
                    end
                    if (vld_q[LAT-1]) begin
                        dout_q <= data_q[LAT-2];
                    end
                end
            end
        end
    endgenerate

    assign dout_o = dout_q;
    assign dvld_o = dvld_q;
endmodule

module dp_lat_mem_ctrl #(
    parameter int A_W    = 6,
    parameter int D_W    = 8,
    parameter int B_W    = 1,
    parameter int W_LAT0 = 3,
    parameter int W_LAT1 = 4,
    parameter int R_LAT0 = 2,
    parameter int R_LAT1 = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en0,
    input  logic           we0,
    input  logic [A_W-1:0] addr0,
    input  logic [D_W-1:0] din0,
    output logic [D_W-1:0] dout0,
    output logic           dvld0,
    input  logic           en1,
    input  logic           we1,
    input  logic [A_W-1:0] addr1,
    input  logic [D_W-1:0] din1,
    output logic [D_W-1:0] dout1,
    output logic           dvld1
);
    localparam int NB  = 1 << B_W;
    localparam int I_W = A_W - B_W;
    localparam int BD  = 1 << I_W;

    logic           act_q;
    logic           wr_go0, wr_go1, rd_go0, rd_go1;
    logic [B_W-1:0] bank0, bank1;
    logic [I_W-1:0] idx0, idx1;
    logic           c0_vld, c1_vld;
    logic [B_W-1:0] c0_bank, c1_bank;
    logic [I_W-1:0] c0_idx, c1_idx;
    logic [D_W-1:0] c0_data, c1_data;
    logic [B_W-1:0] rsel0_q, rsel1_q;
    logic [D_W-1:0] bank_rd0 [NB];
    logic [D_W-1:0] bank_rd1 [NB];
    logic [D_W-1:0] rd_data0, rd_data1;

    // Accept requests only after one full edge out of reset. A request that
    // arrives while reset is asserted, or on the release edge, is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= 1'b0;
        end else begin
            act_q <= 1'b1;
        end
    end

    assign wr_go0 = en0 & we0 & act_q;
    assign wr_go1 = en1 & we1 & act_q;
    assign rd_go0 = en0 & ~we0 & act_q;
    assign rd_go1 = en1 & ~we1 & act_q;

    // The low address bits pick the bank, so sequential words alternate banks.
    assign bank0 = addr0[B_W-1:0];
    assign bank1 = addr1[B_W-1:0];
    assign idx0  = addr0[A_W-1:B_W];
    assign idx1  = addr1[A_W-1:B_W];

    dp_lat_wr_pipe #(.LAT(W_LAT0), .B_W(B_W), .I_W(I_W), .D_W(D_W)) u_wr0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld_i  (wr_go0),
        .in_bank_i (bank0),
        .in_idx_i  (idx0),
        .in_data_i (din0),
        .out_vld_o (c0_vld),
        .out_bank_o(c0_bank),
        .out_idx_o (c0_idx),
        .out_data_o(c0_data)
    );

    dp_lat_wr_pipe #(.LAT(W_LAT1), .B_W(B_W), .I_W(I_W), .D_W(D_W)) u_wr1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld_i  (wr_go1),
        .in_bank_i (bank1),
        .in_idx_i  (idx1),
        .in_data_i (din1),
        .out_vld_o (c1_vld),
        .out_bank_o(c1_bank),
        .out_idx_o (c1_idx),
        .out_data_o(c1_data)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            logic [D_W-1:0] mem_q [BD];
            logic [D_W-1:0] rd0_q, rd1_q;

            // Commit port 1 first, then port 0. On a same-word collision the
            // later port 0 assignment is the value that sticks.
            always_ff @(posedge clk) begin
                if (c1_vld && (c1_bank == B_W'(gi))) begin
                    mem_q[c1_idx] <= c1_data;
                end
                if (c0_vld && (c0_bank == B_W'(gi))) begin
                    mem_q[c0_idx] <= c0_data;
                end
            end

            // Registered reads. They see the array as it was before this
            // edge's commits, which gives read-before-write ordering.
            always_ff @(posedge clk) begin
                if (rd_go0 && (bank0 == B_W'(gi))) begin
                    rd0_q <= mem_q[idx0];
                end
                if (rd_go1 && (bank1 == B_W'(gi))) begin
                    rd1_q <= mem_q[idx1];
                end
            end

            assign bank_rd0[gi] = rd0_q;
            assign bank_rd1[gi] = rd1_q;
        end
    endgenerate

    // Remember which bank each port read so the response can be steered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsel0_q <= '0;
            rsel1_q <= '0;
        end else begin
            if (rd_go0) begin
                rsel0_q <= bank0;
            end
            if (rd_go1) begin
                rsel1_q <= bank1;
            end
        end
    end

    assign rd_data0 = bank_rd0[rsel0_q];
    assign rd_data1 = bank_rd1[rsel1_q];

    dp_lat_rd_pipe #(.LAT(R_LAT0), .D_W(D_W)) u_rd0 (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (rd_go0),
        .data_i(rd_data0),
        .dout_o(dout0),
        .dvld_o(dvld0)
    );

    dp_lat_rd_pipe #(.LAT(R_LAT1), .D_W(D_W)) u_rd1 (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (rd_go1),
        .data_i(rd_data1),
        .dout_o(dout1),
        .dvld_o(dvld1)
    );
endmodule

// File: tb/tb_dp_lat_mem_ctrl.sv
// Scoreboard bench for dp_lat_mem_ctrl. Stimulus pushes expected read data and
// arrival cycles; a negedge monitor pops and compares on every dvld pulse.
module tb_dp_lat_mem_ctrl;
    localparam int A_W    = 6;
    localparam int D_W    = 8;
    localparam int B_W    = 1;
    localparam int W_LAT0 = 3;
    localparam int W_LAT1 = 4;
    localparam int R_LAT0 = 2;
    localparam int R_LAT1 = 3;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           en0 = 1'b0, we0 = 1'b0, en1 = 1'b0, we1 = 1'b0;
    logic [A_W-1:0] addr0 = '0, addr1 = '0;
    logic [D_W-1:0] din0 = '0, din1 = '0;
    logic [D_W-1:0] dout0, dout1;
    logic           dvld0, dvld1;

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    dp_lat_mem_ctrl #(
        .A_W(A_W), .D_W(D_W), .B_W(B_W),
        .W_LAT0(W_LAT0), .W_LAT1(W_LAT1), .R_LAT0(R_LAT0), .R_LAT1(R_LAT1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en0  (en0),
        .we0  (we0),
        .addr0(addr0),
        .din0 (din0),
        .dout0(dout0),
        .dvld0(dvld0),
        .en1  (en1),
        .we1  (we1),
        .addr1(addr1),
        .din1 (din1),
        .dout1(dout1),
        .dvld1(dvld1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: one line per completed read; data and arrival cycle checked.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dvld0) begin
                if (q0.size() == 0) begin
                    n_chk++;
                    $display("FAIL p0_unexpected_dvld: got dout0=0x%0h, required no pulse (cycle %0d)", dout0, cyc);
                end else begin
                    e0 = q0.pop_front();
                    $display("p0 read  dout=0x%02h exp=0x%02h cycle=%0d due=%0d", dout0, e0.d, cyc, e0.due);
                    chk("p0_data", int'(dout0), int'(e0.d));
                    chk("p0_cycle", cyc, e0.due);
                end
            end else if (q0.size() != 0 && q0[0].due <= cyc) begin
                n_chk++;
                $display("FAIL p0_missing_dvld: got dvld0=0 at cycle %0d, required pulse with 0x%0h", cyc, q0[0].d);
                void'(q0.pop_front());
            end
            if (dvld1) begin
                if (q1.size() == 0) begin
                    n_chk++;
                    $display("FAIL p1_unexpected_dvld: got dout1=0x%0h, required no pulse (cycle %0d)", dout1, cyc);
                end else begin
                    e1 = q1.pop_front();
                    $display("p1 read  dout=0x%02h exp=0x%02h cycle=%0d due=%0d", dout1, e1.d, cyc, e1.due);
                    chk("p1_data", int'(dout1), int'(e1.d));
                    chk("p1_cycle", cyc, e1.due);
                end
            end else if (q1.size() != 0 && q1[0].due <= cyc) begin
                n_chk++;
                $display("FAIL p1_missing_dvld: got dvld1=0 at cycle %0d, required pulse with 0x%0h", cyc, q1[0].d);
                void'(q1.pop_front());
            end
        end
    end

    // One clock of stimulus on both ports; reads push their expected response.
    task automatic drive(input logic e0_i, input logic w0_i, input logic [5:0] a0_i,
                         input logic [7:0] d0_i, input logic [7:0] x0_i,
                         input logic e1_i, input logic w1_i, input logic [5:0] a1_i,
                         input logic [7:0] d1_i, input logic [7:0] x1_i);
        exp_t t;
        en0 = e0_i; we0 = w0_i; addr0 = a0_i; din0 = d0_i;
        en1 = e1_i; we1 = w1_i; addr1 = a1_i; din1 = d1_i;
        if (rst_n && e0_i && !w0_i) begin
            t.d = x0_i; t.due = cyc + 1 + R_LAT0; q0.push_back(t);
        end
        if (rst_n && e1_i && !w1_i) begin
            t.d = x1_i; t.due = cyc + 1 + R_LAT1; q1.push_back(t);
        end
        @(posedge clk); #1;
        en0 = 1'b0; we0 = 1'b0; en1 = 1'b0; we1 = 1'b0;
    endtask

    task automatic wr0(input logic [5:0] a, input logic [7:0] d);
        drive(1'b1, 1'b1, a, d, 8'h00, 1'b0, 1'b0, 6'd0, 8'h00, 8'h00);
    endtask
    task automatic rd0(input logic [5:0] a, input logic [7:0] x);
        drive(1'b1, 1'b0, a, 8'h00, x, 1'b0, 1'b0, 6'd0, 8'h00, 8'h00);
    endtask
    task automatic wr1(input logic [5:0] a, input logic [7:0] d);
        drive(1'b0, 1'b0, 6'd0, 8'h00, 8'h00, 1'b1, 1'b1, a, d, 8'h00);
    endtask
    task automatic rd1(input logic [5:0] a, input logic [7:0] x);
        drive(1'b0, 1'b0, 6'd0, 8'h00, 8'h00, 1'b1, 1'b0, a, 8'h00, x);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Reset state.
        idle(3);
        chk("reset_dout0", int'(dout0), 0);
        chk("reset_dvld0", int'(dvld0), 0);
        chk("reset_dout1", int'(dout1), 0);
        chk("reset_dvld1", int'(dvld1), 0);
        rst_n = 1'b1;
        idle(2);

        // Single write then read; port 1 sees the port 0 write too.
        wr0(6'd5, 8'hA5);
        idle(W_LAT0);
        rd0(6'd5, 8'hA5);
        rd1(6'd5, 8'hA5);
        idle(4);

        // Read-before-commit hazard: the commit edge read still sees 0x11.
        wr0(6'd7, 8'h11);
        idle(5);
        wr1(6'd7, 8'h22);
        idle(W_LAT1 - 1);
        rd0(6'd7, 8'h11);
        rd0(6'd7, 8'h22);
        idle(4);

        // Same-edge collision: both commit together, port 0 wins.
        wr1(6'd9, 8'h44);
        wr0(6'd9, 8'h33);
        idle(4);
        rd0(6'd9, 8'h33);
        rd1(6'd9, 8'h33);
        idle(5);

        // Back-to-back streaming on port 1.
        for (int a = 0; a < 16; a++) wr1(6'(a), 8'(a) ^ 8'hFF);
        for (int a = 0; a < 16; a++) rd1(6'(a), 8'(a) ^ 8'hFF);
        idle(5);

        // Reset mid-flight: the 0x77 write and a pending read are dropped.
        wr0(6'd3, 8'h01);
        idle(4);
        rd0(6'd3, 8'h01);
        idle(4);
        wr0(6'd3, 8'h77);
        rd0(6'd5, 8'hA5);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_dout0", int'(dout0), 0);
        chk("rst_dvld0", int'(dvld0), 0);
        chk("rst_dout1", int'(dout1), 0);
        chk("rst_dvld1", int'(dvld1), 0);
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        wr0(6'd3, 8'h55);
        idle(1);
        rst_n = 1'b1;
        idle(2);
        rd0(6'd3, 8'h01);
        idle(4);

        // Bank independence: even reads on port 0 against odd writes on port 1.
        for (int i = 0; i < 32; i++) wr0(6'(2 * i), 8'(i * 3 + 1));
        idle(5);
        for (int i = 0; i < 32; i++)
            drive(1'b1, 1'b0, 6'(2 * i), 8'h00, 8'(i * 3 + 1),
                  1'b1, 1'b1, 6'(2 * i + 1), 8'(i) ^ 8'h5A, 8'h00);
        idle(6);
        for (int i = 0; i < 32; i++) rd1(6'(2 * i + 1), 8'(i) ^ 8'h5A);
        idle(8);

        chk("p0_queue_drained", q0.size(), 0);
        chk("p1_queue_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time %0t, required finish earlier", $time);
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
